// File: rtl/bcd_scan_display.sv
// Binary-to-BCD converter (shift-add-3, one bit per clock) feeding a
// multiplexed 7-segment scanner with leading-zero blanking and overflow dashes.
module bcd_scan_display #(
    parameter int WIDTH    = 8,
    parameter int DIGITS   = 3,
    parameter int SCAN_DIV = 1000,
    parameter int SEG_INV  = 0
) (
    input  logic              clock,
    input  logic              Reset,
    input  logic [WIDTH-1:0]  IN,
    input  logic              load,
    input  logic              blank_en,
    output logic              busy,
    output logic              done,
    output logic              ovf,
    output logic [DIGITS-1:0] S,
    output logic [6:0]        LED
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    localparam logic [DIGITS-1:0] INV_S = (SEG_INV != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
    localparam logic [6:0]        INV_L = (SEG_INV != 0) ? 7'h7F : 7'h00;

    function automatic logic [31:0] max_value(input int unsigned n);
        logic [31:0] p;
        p = 32'd1;
        for (int unsigned k = 0; k < n; k++) p = p * 32'd10;
        return p - 32'd1;
    endfunction

    localparam logic [31:0] MAX_VAL = max_value(DIGITS);

    function automatic logic [6:0] seg_of(input logic [3:0] nib);
        case (nib)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    logic [1:0]       state;
    logic [CW-1:0]    bit_cnt;
    logic [WIDTH-1:0] bin_sr;
    logic [BW-1:0]    bcd_sr;
    logic [BW-1:0]    bcd_adj;
    logic             ovf_next;
    logic [BW-1:0]    disp;
    logic [31:0]      in_ext;

    logic [PW-1:0]     presc;
    logic [IW-1:0]     idx;
    logic [3:0]        cur_nib;
    logic              nz_above;
    logic [6:0]        seg_next;
    logic [DIGITS-1:0] sel_next;

    assign busy   = (state != ST_IDLE);
    assign in_ext = 32'(IN);

    // Add 3 to every BCD nibble that is 5 or more before the shift
    always_comb begin
        bcd_adj = bcd_sr;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (bcd_sr[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_sr[4*i +: 4] + 4'd3;
        end
    end

    // Conversion FSM: capture, WIDTH shift cycles, commit to display register
    always_ff @(posedge clock) begin
        if (Reset) begin
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            bin_sr   <= '0;
            bcd_sr   <= '0;
            ovf_next <= 1'b0;
            disp     <= '0;
            ovf      <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (load) begin
                        bin_sr   <= IN;
                        bcd_sr   <= '0;
                        ovf_next <= (in_ext > MAX_VAL);
                        bit_cnt  <= '0;
                        state    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    {bcd_sr, bin_sr} <= {bcd_adj[BW-2:0], bin_sr, 1'b0};
                    if (bit_cnt == CW'(WIDTH - 1)) state <= ST_COMMIT;
                    else                           bit_cnt <= bit_cnt + 1'b1;
                end
                ST_COMMIT: begin
                    disp  <= bcd_sr;
                    ovf   <= ovf_next;
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Free-running dwell prescaler and digit scan index
    always_ff @(posedge clock) begin
        if (Reset) begin
            presc <= '0;
            idx   <= '0;
        end else if (presc == PW'(SCAN_DIV - 1)) begin
            presc <= '0;
            idx   <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // Segment pattern for the current slot: dashes on overflow, else blanking, else digit
    always_comb begin
        cur_nib  = 4'd0;
        nz_above = 1'b0;
        sel_next = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) begin
                cur_nib     = disp[4*i +: 4];
                sel_next[i] = 1'b1;
            end
            if (IW'(i) >= idx && disp[4*i +: 4] != 4'd0) nz_above = 1'b1;
        end
        if (ovf)                                  seg_next = 7'h40;
        else if (blank_en && idx != '0 && !nz_above) seg_next = 7'h00;
        else                                      seg_next = seg_of(cur_nib);
    end

    // Output register: select and segments change on the same edge
    always_ff @(posedge clock) begin
        if (Reset) begin
            S   <= DIGITS'(1) ^ INV_S;
            LED <= 7'h3F ^ INV_L;
        end else begin
            S   <= sel_next ^ INV_S;
            LED <= seg_next ^ INV_L;
        end
    end

endmodule

// File: doc/bcd_scan_display.md
Name: bcd_scan_display

Overview:
Parametrised successor to the fixed 8-bit, 3-digit BCD conversion and 7-segment display path. It captures a WIDTH-bit binary value on a load handshake and converts it to DIGITS BCD digits sequentially using shift-add-3, one bit per clock. It then time-multiplexes the digits onto a shared segment bus, with optional leading-zero blanking and overflow indication. It sits between the CPU output port and the board's 7-segment digit-select and segment pins.

Parameters:
WIDTH, 8, binary input width (1..32)
DIGITS, 3, number of displayed decimal digits (1..8)
SCAN_DIV, 1000, clocks per digit dwell (>=2)
SEG_INV, 0, 1 = invert both S and LED at the output register (common-anode boards)

Ports:
clock  input  1  system clock; all logic on rising edge
Reset  input  1  synchronous, active-high reset
IN  input  WIDTH  binary value to display
load  input  1  request to convert IN
blank_en  input  1  1 = blank leading zeros
busy  output  1  conversion in progress; load ignored while high
done  output  1  one-cycle pulse when the display register updates
ovf  output  1  latched: last accepted value > 10^DIGITS-1
S  output  DIGITS  one-hot digit select, S[0] = least significant digit
LED  output  7  segments, LED[0]=a .. LED[6]=g, active-high before SEG_INV

Behaviour:
- Reset (sync, Reset=1 at clock edge): FSM=IDLE; busy=0; done=0; ovf=0; display register=all zero; scan index=0; prescaler=0; S=one-hot bit 0; LED=7'h3F ("0"). SEG_INV inverts these output values. Reset has priority over all other inputs.
- Reset mid-conversion aborts the conversion. The display register clears; the previous value is not retained.
- FSM IDLE -> SHIFT -> COMMIT -> IDLE.
- IDLE: load=1 captures IN into the shift register and zeroes the BCD accumulator (4*DIGITS bits). It also captures ovf_next = (IN > 10^DIGITS-1), computed with a compile-time constant. busy goes high on the next cycle.
- SHIFT: runs exactly WIDTH cycles. Each cycle, every nibble >=5 gets +3, then the combined {BCD, binary} register shifts left by 1. A bit counter runs 0..WIDTH-1.
- COMMIT: one cycle. The display register takes the BCD accumulator, ovf takes ovf_next, and done=1 for this cycle only. Next state is IDLE with busy=0.
- Latency: load sampled at edge 0 -> busy=1 for edges 1..WIDTH+1 -> display register and done valid after edge WIDTH+1. Total WIDTH+2 cycles from load to the next accepted load.
- load while busy=1 is ignored, with no queuing. load held high continuously reconverts back-to-back, each conversion sampling IN on its IDLE cycle.
- The display register holds its value between conversions. The scan runs independently of the FSM and never stalls.
- Scan: the prescaler counts 0..SCAN_DIV-1. At terminal count it resets to 0 and the scan index advances, wrapping from DIGITS-1 to 0. S and LED are registered and update together on the same edge, one cycle after the index changes. There are no glitch cycles with two digits selected.
- Segment decode: 0-9 standard patterns (0=3F,1=06,2=5B,3=4F,4=66,5=6D,6=7D,7=07,8=7F,9=6F). Nibbles >9 cannot occur.
- Overflow: when ovf=1, every digit shows "-" (7'h40) regardless of blank_en. The BCD value of the truncated conversion is still stored but not shown.
- Blanking: with blank_en=1, a digit i>0 is blank (7'h00) when digit i and all digits above it are zero. Digit 0 is never blanked. blank_en is sampled combinationally per scan slot, so it takes effect within one dwell.

Test Plan:
- Reset/idle: assert Reset 2 cycles, release -> S=3'b001, LED=7'h3F, busy=0, ovf=0. With SCAN_DIV=4, S steps 001->010->100->001 every 4 cycles.
- Conversion: IN=8'd255, load 1 cycle -> busy high 9 cycles, done pulses on cycle 10. Digits read 5,5,2 (LED 6D,6D,5B on S=001,010,100).
- Blanking: IN=7, blank_en=1 -> digit0=07, digits 1,2=00. With blank_en=0 -> 07,3F,3F. IN=105 with blanking -> 6D,3F,06 (the inner zero is kept).
- Load during busy: load IN=200, then load IN=9 two cycles later -> second load ignored. Display shows 200 and exactly one done pulse occurs.
- Overflow: DIGITS=2, IN=100 -> ovf=1, both digits 7'h40. A following load of IN=99 -> ovf=0, display 9,9.
- Reset mid-conversion: Reset at SHIFT cycle 4 -> busy=0, done never pulses, display 0. A load next cycle converts normally.
